mux2_sync: RTL and testbench

- Registered 2:1 data selector: `data_in_1` when `sel`=1, else `data_in_0`, presented on `data_out` one clock later.
- Leaf datapath primitive for steering between two sources where a clean, glitch-free registered output is required.
- Adds an input/output valid qualifier so downstream logic can tell fresh samples from idle cycles.

---
 rtl/mux2_sync.sv | 86 ++++++++
 tb/tb_mux2_sync.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_sync.sv
// Registered 2:1 selector with valid qualifier; one-cycle latency, full throughput.
// Optional per-source sample counters are enabled by defining MUX2_SYNC_STATS_EN.
module mux2_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in_0,
   input  logic [WIDTH-1:0] data_in_1,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid
`ifdef MUX2_SYNC_STATS_EN
   ,
   output logic [15:0]      sel0_count,
   output logic [15:0]      sel1_count
`endif
);

   logic [WIDTH-1:0] w_sel_data;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // Source selection ahead of the output register
   always_comb begin
      w_sel_data = data_in_0;
      if (sel) begin
         w_sel_data = data_in_1;
      end else begin
         w_sel_data = data_in_0;
      end
   end

   // Output register: data holds on idle cycles, valid is a one-cycle strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= RST_VAL;
         r_valid <= 1'b0;
      end else if (in_valid) begin
         r_data  <= w_sel_data;
         r_valid <= 1'b1;
      end else begin
         r_data  <= r_data;
         r_valid <= 1'b0;
      end
   end

   assign data_out  = r_data;
   assign out_valid = r_valid;

`ifdef MUX2_SYNC_STATS_EN
   logic [15:0] r_sel0_cnt;
   logic [15:0] r_sel1_cnt;

   function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   // Per-source accepted-sample counters, saturating rather than wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel0_cnt <= 16'd0;
         r_sel1_cnt <= 16'd0;
      end else if (in_valid) begin
         if (sel) begin
            r_sel1_cnt <= f_sat_inc(r_sel1_cnt);
         end else begin
            r_sel0_cnt <= f_sat_inc(r_sel0_cnt);
         end
      end else begin
         r_sel0_cnt <= r_sel0_cnt;
         r_sel1_cnt <= r_sel1_cnt;
      end
   end

   assign sel0_count = r_sel0_cnt;
   assign sel1_count = r_sel1_cnt;
`endif

endmodule

// File: tb/tb_mux2_sync.sv
// Self-checking bench for mux2_sync: a 1-bit and an 8-bit instance share control inputs.
// Covers the optional counters when MUX2_SYNC_STATS_EN is defined.
module tb_mux2_sync;

   localparam logic [7:0] RST_W = 8'h5A;

   logic       clk;
   logic       rst;
   logic       sel;
   logic       in_valid;
   logic       n_d0, n_d1, n_out, n_vld;
   logic [7:0] wd0, wd1, w_out;
   logic       w_vld;
`ifdef MUX2_SYNC_STATS_EN
   logic [15:0] n_c0, n_c1, w_c0, w_c1;
`endif

   // Reference model state
   logic       m_n;
   logic [7:0] m_w;
   logic       m_v;
   int         m_c0, m_c1;

   int n_cmp = 0;
   int n_err = 0;

   mux2_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_narrow (
      .clk(clk), .rst(rst), .data_in_0(n_d0), .data_in_1(n_d1), .sel(sel),
      .in_valid(in_valid), .data_out(n_out), .out_valid(n_vld)
`ifdef MUX2_SYNC_STATS_EN
      , .sel0_count(n_c0), .sel1_count(n_c1)
`endif
   );

   mux2_sync #(.WIDTH(8), .RST_VAL(RST_W)) u_wide (
      .clk(clk), .rst(rst), .data_in_0(wd0), .data_in_1(wd1), .sel(sel),
      .in_valid(in_valid), .data_out(w_out), .out_valid(w_vld)
`ifdef MUX2_SYNC_STATS_EN
      , .sel0_count(w_c0), .sel1_count(w_c1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance the model with the inputs presented now, then cross the edge
   task automatic tick();
      if (rst) begin
         m_n = 1'b0; m_w = RST_W; m_v = 1'b0; m_c0 = 0; m_c1 = 0;
      end else if (in_valid) begin
         m_n = sel ? n_d1 : n_d0;
         m_w = sel ? wd1 : wd0;
         m_v = 1'b1;
         if (sel) m_c1 = (m_c1 < 65535) ? m_c1 + 1 : 65535;
         else     m_c0 = (m_c0 < 65535) ? m_c0 + 1 : 65535;
      end else begin
         m_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".n_data"},  {31'd0, n_out}, {31'd0, m_n});
      chk({tag, ".n_valid"}, {31'd0, n_vld}, {31'd0, m_v});
      chk({tag, ".w_data"},  {24'd0, w_out}, {24'd0, m_w});
      chk({tag, ".w_valid"}, {31'd0, w_vld}, {31'd0, m_v});
`ifdef MUX2_SYNC_STATS_EN
      chk({tag, ".n_c0"}, {16'd0, n_c0}, m_c0);
      chk({tag, ".n_c1"}, {16'd0, n_c1}, m_c1);
      chk({tag, ".w_c0"}, {16'd0, w_c0}, m_c0);
      chk({tag, ".w_c1"}, {16'd0, w_c1}, m_c1);
`endif
   endtask

   task automatic rand_inputs();
      n_d0 = 1'($urandom); n_d1 = 1'($urandom);
      wd0  = 8'($urandom); wd1  = 8'($urandom);
      sel  = 1'($urandom);
   endtask

   typedef struct {
      logic d0;
      logic d1;
      logic s;
      logic exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

      m_n = 1'b0; m_w = RST_W; m_v = 1'b0; m_c0 = 0; m_c1 = 0;
      rst = 1'b1; in_valid = 1'b1; sel = 1'b0;
      n_d0 = 1'b1; n_d1 = 1'b1; wd0 = 8'hFF; wd1 = 8'hFF;

      // Reset held two cycles with inputs toggling
      for (int i = 0; i < 2; i++) begin
         n_d0 = ~n_d0; n_d1 = (i == 0); sel = ~sel; wd0 = ~wd0;
         tick();
         chk("reset.n_data",  {31'd0, n_out}, 32'd0);
         chk("reset.n_valid", {31'd0, n_vld}, 32'd0);
         chk("reset.w_data",  {24'd0, w_out}, {24'd0, RST_W});
         check_all("reset");
      end

      // Truth table
      rst = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_d0 = tbl[i].d0; n_d1 = tbl[i].d1; sel = tbl[i].s;
         wd0 = 8'($urandom); wd1 = 8'($urandom);
         tick();
         chk($sformatf("tt%0d.data", i), {31'd0, n_out}, {31'd0, tbl[i].exp});
         chk($sformatf("tt%0d.valid", i), {31'd0, n_vld}, 32'd1);
         check_all("tt");
      end

      // Hold: capture 1, then idle with changing inputs
      n_d0 = 1'b1; n_d1 = 1'b0; sel = 1'b0; in_valid = 1'b1;
      tick();
      chk("hold.capture", {31'd0, n_out}, 32'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_d0 = 1'b0; n_d1 = 1'($urandom); sel = ~sel; wd0 = 8'($urandom); wd1 = 8'($urandom);
         tick();
         chk("hold.data",  {31'd0, n_out}, 32'd1);
         chk("hold.valid", {31'd0, n_vld}, 32'd0);
         check_all("hold");
      end

      // Wide data, sel alternating 0/1/0
      in_valid = 1'b1; wd0 = 8'hA5; wd1 = 8'h3C;
      sel = 1'b0; tick(); chk("wide.0", {24'd0, w_out}, 32'hA5); check_all("wide");
      sel = 1'b1; tick(); chk("wide.1", {24'd0, w_out}, 32'h3C); check_all("wide");
      sel = 1'b0; tick(); chk("wide.2", {24'd0, w_out}, 32'hA5); check_all("wide");

      // Mid-stream reset during continuous valid traffic
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); tick(); check_all("pre_rst");
      end
      rst = 1'b1; rand_inputs(); tick();
      chk("midrst.w_data", {24'd0, w_out}, {24'd0, RST_W});
      chk("midrst.valid",  {31'd0, w_vld}, 32'd0);
      check_all("midrst");
      rst = 1'b0; wd0 = 8'h11; wd1 = 8'h22; sel = 1'b1; tick();
      chk("resume.w_data", {24'd0, w_out}, 32'h22);
      chk("resume.valid",  {31'd0, w_vld}, 32'd1);
      check_all("resume");

`ifdef MUX2_SYNC_STATS_EN
      // Counter scenario: 3 sel0, 2 sel1, 4 idle, then reset
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rand_inputs();
         in_valid = (i % 2 == 0);
         sel = (i >= 6);
         tick(); check_all("stats");
      end
      in_valid = 1'b0; tick();
      chk("stats.c0", {16'd0, w_c0}, 32'd3);
      chk("stats.c1", {16'd0, w_c1}, 32'd2);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("stats.rst_c0", {16'd0, w_c0}, 32'd0);
      chk("stats.rst_c1", {16'd0, n_c1}, 32'd0);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 300; i++) begin
         rand_inputs();
         in_valid = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 24) == 0);
         tick();
         check_all("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
